// File: rtl/irq_defs.sv
// Shared definitions for the nested interrupt controller:
// register map, FSM encoding and vector defaults.
package irq_defs;

  localparam logic [1:0] AD_ENABLE    = 2'd0;
  localparam logic [1:0] AD_PENDING   = 2'd1;
  localparam logic [1:0] AD_INSERVICE = 2'd2;
  localparam logic [1:0] AD_RSVD      = 2'd3;

  localparam logic [15:0] VEC_BASE_DEF   = 16'h0020;
  localparam int          VEC_STRIDE_DEF = 4;

  localparam int IDX_W = 3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_TAKE = 2'd1,
    S_HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: the lowest set request index wins.
module irq_prio_enc
  import irq_defs::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0]     req,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  always_comb begin
    valid = |req;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// Nested priority interrupt controller with in-service stack.
// Define IRQ_CTRL_EDGE_EN for rising-edge detection; default is level.
module irq_ctrl
  import irq_defs::*;
#(
  parameter int          N_SRC      = 8,
  parameter logic [15:0] VEC_BASE   = VEC_BASE_DEF,
  parameter int          VEC_STRIDE = VEC_STRIDE_DEF,
  parameter int          MAX_DEPTH  = 3
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [N_SRC-1:0] i_irq,
  input  logic             i_int_en,
  input  logic             i_iret_detected,
  input  logic             i_sel,
  input  logic             i_we,
  input  logic [1:0]       i_ad,
  input  logic [7:0]       i_data_in,
  output logic [7:0]       o_data_out,
  output logic             o_irq_take,
  output logic [15:0]      o_irq_vector,
  output logic [1:0]       o_depth
);

  state_t state, state_n;
  logic   hold_cnt;
  logic   int_en_q;

  logic [N_SRC-1:0] enable;
  logic [N_SRC-1:0] pending;
  logic [N_SRC-1:0] det;
  logic [N_SRC-1:0] clr;
  logic [N_SRC-1:0] elig;
  logic [N_SRC-1:0] cand;

  logic [IDX_W-1:0] stk [4];
  logic [1:0]       depth;
  logic [1:0]       d_pop;
  logic [IDX_W-1:0] top;
  logic [IDX_W-1:0] take_idx;
  logic [IDX_W-1:0] enc_idx;
  logic             enc_valid;
  logic [7:0]       insvc;

  logic take, pop, go, wr_en, wr_pend;

  assign take    = (state == S_TAKE);
  assign pop     = i_iret_detected && (depth != 2'd0);
  assign d_pop   = pop ? depth - 2'd1 : depth;
  assign top     = stk[depth - 2'd1];
  assign wr_en   = i_sel && i_we && (i_ad == AD_ENABLE);
  assign wr_pend = i_sel && i_we && (i_ad == AD_PENDING);

`ifdef IRQ_CTRL_EDGE_EN
  logic [N_SRC-1:0] irq_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) irq_q <= '0;
    else       irq_q <= i_irq;
  end

  assign det = i_irq & ~irq_q;
`else
  assign det = i_irq;
`endif

  // Nesting: only strictly higher priority than the active handler.
  always_comb begin
    elig = '0;
    for (int i = 0; i < N_SRC; i++) begin
      elig[i] = (depth == 2'd0) || (IDX_W'(i) < top);
    end
  end

  assign cand = pending & enable & elig;

  irq_prio_enc #(
    .N(N_SRC)
  ) u_enc (
    .req  (cand),
    .valid(enc_valid),
    .idx  (enc_idx)
  );

  assign go = (state == S_IDLE) && int_en_q && enc_valid
           && (int'(depth) < MAX_DEPTH);

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:  if (go) state_n = S_TAKE;
      S_TAKE:  state_n = S_HOLD;
      S_HOLD:  if (hold_cnt) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= S_IDLE;
      hold_cnt <= 1'b0;
      int_en_q <= 1'b0;
      take_idx <= '0;
    end else begin
      state    <= state_n;
      hold_cnt <= (state == S_HOLD) ? ~hold_cnt : 1'b0;
      int_en_q <= i_int_en;
      if (go) take_idx <= enc_idx;
    end
  end

  // A new detection wins over any clear in the same cycle.
  always_comb begin
    clr = '0;
    if (wr_pend) clr = i_data_in[N_SRC-1:0];
    if (take)    clr[take_idx] = 1'b1;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      enable  <= '0;
      pending <= '0;
    end else begin
      pending <= (pending & ~clr) | det;
      if (wr_en) enable <= i_data_in[N_SRC-1:0];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      depth <= 2'd0;
      for (int j = 0; j < 4; j++) stk[j] <= '0;
    end else if (take) begin
      stk[d_pop] <= take_idx;
      depth      <= d_pop + 2'd1;
    end else if (pop) begin
      depth <= d_pop;
    end
  end

  always_comb begin
    insvc = '0;
    for (int j = 0; j < 4; j++) begin
      if (j < int'(depth)) insvc[stk[j]] = 1'b1;
    end
  end

  always_comb begin
    o_data_out = '0;
    unique case (1'b1)
      (i_ad == AD_ENABLE):    o_data_out = 8'(enable);
      (i_ad == AD_PENDING):   o_data_out = 8'(pending);
      (i_ad == AD_INSERVICE): o_data_out = insvc;
      (i_ad == AD_RSVD):      o_data_out = '0;
      default:                o_data_out = '0;
    endcase
  end

  assign o_irq_take   = take;
  assign o_irq_vector = take
    ? VEC_BASE + 16'(take_idx) * 16'(VEC_STRIDE)
    : 16'h0000;
  assign o_depth      = depth;

endmodule

// File: tb/tb_irq_ctrl.sv
// Scoreboard bench for irq_ctrl: expected takes are queued with
// their vector and cycle, and matched when the DUT pulses take.
module tb_irq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  irq;
  logic        int_en;
  logic        iret;
  logic        sel;
  logic        we;
  logic [1:0]  ad;
  logic [7:0]  din;
  logic [7:0]  dout;
  logic        take;
  logic [15:0] vec;
  logic [1:0]  depth;

  typedef struct {
    logic [15:0] vec;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_run = 0;
  int   n_fail = 0;

  irq_ctrl dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_irq          (irq),
    .i_int_en       (int_en),
    .i_iret_detected(iret),
    .i_sel          (sel),
    .i_we           (we),
    .i_ad           (ad),
    .i_data_in      (din),
    .o_data_out     (dout),
    .o_irq_take     (take),
    .o_irq_vector   (vec),
    .o_depth        (depth)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (take) begin
        if (sb.size() == 0) begin
          chk("take_unexp", {16'd0, vec}, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("take_vec", {16'd0, vec}, {16'd0, e.vec});
          chk("take_cyc", cyc, e.cyc);
        end
      end else begin
        if (vec != 16'd0) chk("vec_idle", {16'd0, vec}, 32'd0);
        if (sb.size() > 0 && sb[0].cyc < cyc) begin
          void'(sb.pop_front());
          chk("take_miss", 32'd0, 32'd1);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic expect_take(input logic [15:0] v, input int dly);
    exp_t e;
    e.vec = v;
    e.cyc = cyc + dly;
    sb.push_back(e);
  endtask

  task automatic pulse(input logic [7:0] m);
    irq = m;
    tick();
    irq = '0;
  endtask

  task automatic do_iret();
    iret = 1'b1;
    tick();
    iret = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    sel = 1'b1;
    we  = 1'b1;
    ad  = a;
    din = d;
    tick();
    sel = 1'b0;
    we  = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [1:0] a,
                    input logic [7:0] exp);
    sel = 1'b1;
    we  = 1'b0;
    ad  = a;
    #1;
    chk(tag, {24'd0, dout}, {24'd0, exp});
    sel = 1'b0;
  endtask

  initial begin
    rst    = 1'b1;
    irq    = '0;
    int_en = 1'b0;
    iret   = 1'b0;
    sel    = 1'b0;
    we     = 1'b0;
    ad     = '0;
    din    = '0;
    wait_n(3);
    chk("rst_take", {31'd0, take}, 32'd0);
    chk("rst_vec", {16'd0, vec}, 32'd0);
    chk("rst_depth", {30'd0, depth}, 32'd0);
    rst = 1'b0;
    tick();
    rd("rst_pend", 2'd1, 8'h00);
    rd("rst_en", 2'd0, 8'h00);

    // Basic take of source 2
    wr(2'd0, 8'h04);
    rd("en_rd", 2'd0, 8'h04);
    int_en = 1'b1;
    expect_take(16'h0028, 2);
    pulse(8'h04);
    wait_n(4);
    chk("d1", {30'd0, depth}, 32'd1);
    rd("insvc_2", 2'd2, 8'h04);
    rd("rsvd", 2'd3, 8'h00);

    // Nesting: 5 blocked, 0 preempts
    wr(2'd0, 8'h25);
    pulse(8'h20);
    wait_n(4);
    rd("pend_5", 2'd1, 8'h20);
    chk("d1_blk", {30'd0, depth}, 32'd1);
    expect_take(16'h0020, 2);
    pulse(8'h01);
    wait_n(4);
    chk("d2", {30'd0, depth}, 32'd2);
    rd("insvc_20", 2'd2, 8'h05);
    wr(2'd2, 8'hff);
    rd("insvc_ro", 2'd2, 8'h05);
    wr(2'd1, 8'h20);
    rd("w1c_5", 2'd1, 8'h00);
    do_iret();
    chk("iret_d1", {30'd0, depth}, 32'd1);
    do_iret();
    chk("iret_d0", {30'd0, depth}, 32'd0);

    // Stray IRETs at depth 0
    for (int k = 0; k < 4; k++) begin
      do_iret();
      tick();
      chk("stray", {30'd0, depth}, 32'd0);
    end

    // Nest 2, 1, 0 up to the depth limit
    wr(2'd0, 8'h0f);
    for (int s = 2; s >= 0; s--) begin
      logic [7:0] m;
      m = 8'h01 << s;
      expect_take(16'h0020 + 16'(s) * 16'd4, 2);
      pulse(m);
      wait_n(4);
    end
    chk("d3", {30'd0, depth}, 32'd3);
    rd("insvc_210", 2'd2, 8'h07);
    for (int k = 0; k < 3; k++) do_iret();
    chk("unwind", {30'd0, depth}, 32'd0);

    // Depth cap: 3, 2, 1 stacked, 0 waits for an IRET
    for (int s = 3; s >= 1; s--) begin
      logic [7:0] m;
      m = 8'h01 << s;
      expect_take(16'h0020 + 16'(s) * 16'd4, 2);
      pulse(m);
      wait_n(4);
    end
    pulse(8'h01);
    wait_n(6);
    rd("pend_cap", 2'd1, 8'h01);
    chk("d3_cap", {30'd0, depth}, 32'd3);
    expect_take(16'h0020, 2);
    do_iret();
    wait_n(4);
    chk("d3_again", {30'd0, depth}, 32'd3);
    rd("insvc_320", 2'd2, 8'h0d);
    for (int k = 0; k < 3; k++) do_iret();
    chk("unwind2", {30'd0, depth}, 32'd0);

    // int_en gating
    int_en = 1'b0;
    wr(2'd0, 8'h08);
    tick();
    pulse(8'h08);
    wait_n(4);
    rd("pend_3", 2'd1, 8'h08);
    chk("gate_d0", {30'd0, depth}, 32'd0);
    int_en = 1'b1;
    expect_take(16'h002c, 2);
    wait_n(5);
    chk("gate_d1", {30'd0, depth}, 32'd1);
    do_iret();
    int_en = 1'b0;
    tick();
    pulse(8'h08);
    wait_n(3);
    wr(2'd1, 8'h08);
    rd("w1c_3", 2'd1, 8'h00);
    int_en = 1'b1;
    wait_n(6);
    chk("w1c_nt", {30'd0, depth}, 32'd0);

    // Reset during HOLD
    expect_take(16'h002c, 2);
    pulse(8'h0c);
    wait_n(2);
    chk("hold_d1", {30'd0, depth}, 32'd1);
    rst = 1'b1;
    #1;
    chk("ar_take", {31'd0, take}, 32'd0);
    chk("ar_vec", {16'd0, vec}, 32'd0);
    chk("ar_depth", {30'd0, depth}, 32'd0);
    rd("ar_pend", 2'd1, 8'h00);
    tick();
    rst = 1'b0;
    wait_n(5);
    rd("ar_en", 2'd0, 8'h00);
    chk("ar_d0", {30'd0, depth}, 32'd0);
    chk("sb_empty", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
